// File: rtl/rfft_ctrl.sv
// rfft_ctrl: stage and address sequencer for the 256-point radix-2 RFFT.
// It steps four 64-entry banks through STAGES butterfly passes. Each pass
// reads every bank address once and then drains the PE pipeline. This keeps
// every write of one pass ahead of all reads of the next pass.
// Optional feature: define RFFT_CTRL_ABORT_EN to add the `abort` input.

module rfft_ctrl #(
    parameter int ADDR_W = 6,
    parameter int STAGES = 7,
    parameter int PE_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
`ifdef RFFT_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [2:0]        stage,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [ADDR_W-1:0] wr_addr1,
    output logic              we,
    output logic              in_swap,
    output logic              out_swap,
    output logic [ADDR_W-1:0] tf_addr,
    output logic              bypass_n
);

    localparam int L    = PE_LAT + 1;
    localparam int FC_W = (L > 1) ? $clog2(L) : 1;
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [FC_W-1:0]     fc_q, fc_d;
    logic [2:0]          stage_q, stage_d;
    logic                abort_hit;

    logic                rd_act;
    logic [ADDR_W-1:0]   inv_mask, in_sel, out_sel;
    logic                os_q;

    logic                pv_q  [PE_LAT];
    logic [ADDR_W-1:0]   pa0_q [PE_LAT];
    logic [ADDR_W-1:0]   pa1_q [PE_LAT];
    logic                ps_q  [PE_LAT];

    assign stage = stage_q;

    // Sequencer state: phase, read counter, flush counter and stage index.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fc_q    <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
            stage_q <= stage_d;
        end
    end

    // Next-state logic. cnt holds at its maximum through FLUSH and only wraps on re-entry to READ.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fc_d      = fc_q;
        stage_d   = stage_q;
        abort_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            READ: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = FLUSH;
                    fc_d    = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            FLUSH: begin
                fc_d = fc_q + FC_W'(1);
                if (fc_q == FC_W'(L - 1)) begin
                    fc_d = '0;
                    if (stage_q == 3'(STAGES - 1)) begin
                        state_d = DONE;
                        stage_d = '0;
                    end else begin
                        state_d = READ;
                        cnt_d   = '0;
                        stage_d = stage_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef RFFT_CTRL_ABORT_EN
        if (abort && (state_q == READ || state_q == FLUSH)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            fc_d      = '0;
            stage_d   = '0;
            abort_hit = 1'b1;
        end
`endif
    end

    // Stage-dependent masks: the inverted top bits for bank 2/3 and the swap-select bit positions.
    always_comb begin
        rd_act   = (state_d == READ);
        inv_mask = ~(CNT_MAX >> stage_d);
        in_sel   = '0;
        out_sel  = '0;
        if (stage_d != 3'd0 && int'(stage_d) <= ADDR_W)
            in_sel = ADDR_W'(1) << (ADDR_W - int'(stage_d));
        if (int'(stage_d) < ADDR_W && stage_d != 3'(STAGES - 1))
            out_sel = ADDR_W'(1) << (ADDR_W - 1 - int'(stage_d));
    end

    // Read-side outputs are registered from the next-state values so that they line up with the phase.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            in_swap  <= 1'b0;
            tf_addr  <= '0;
            bypass_n <= 1'b1;
            os_q     <= 1'b0;
        end else begin
            busy     <= (state_d == READ) || (state_d == FLUSH);
            done     <= (state_d == DONE);
            rd_addr0 <= rd_act ? cnt_d : '0;
            rd_addr1 <= rd_act ? (cnt_d ^ inv_mask) : '0;
            in_swap  <= rd_act && (|(cnt_d & in_sel));
            tf_addr  <= rd_act ? (cnt_d << stage_d) : '0;
            bypass_n <= (stage_d != 3'(STAGES - 1));
            os_q     <= rd_act && (|(cnt_d & out_sel));
        end
    end

    // Write-back delay line. A read issued in cycle t is written in cycle t+L. Abort drops anything in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < PE_LAT; i++) begin
                pv_q[i]  <= 1'b0;
                pa0_q[i] <= '0;
                pa1_q[i] <= '0;
                ps_q[i]  <= 1'b0;
            end
            we       <= 1'b0;
            wr_addr0 <= '0;
            wr_addr1 <= '0;
            out_swap <= 1'b0;
        end else if (abort_hit) begin
            for (int i = 0; i < PE_LAT; i++) begin
                pv_q[i] <= 1'b0;
            end
            we       <= 1'b0;
            wr_addr0 <= '0;
            wr_addr1 <= '0;
            out_swap <= 1'b0;
        end else begin
            pv_q[0]  <= (state_q == READ);
            pa0_q[0] <= rd_addr0;
            pa1_q[0] <= rd_addr1;
            ps_q[0]  <= os_q;
            for (int i = 1; i < PE_LAT; i++) begin
                pv_q[i]  <= pv_q[i-1];
                pa0_q[i] <= pa0_q[i-1];
                pa1_q[i] <= pa1_q[i-1];
                ps_q[i]  <= ps_q[i-1];
            end
            we       <= pv_q[PE_LAT-1];
            wr_addr0 <= pv_q[PE_LAT-1] ? pa0_q[PE_LAT-1] : '0;
            wr_addr1 <= pv_q[PE_LAT-1] ? pa1_q[PE_LAT-1] : '0;
            out_swap <= pv_q[PE_LAT-1] && ps_q[PE_LAT-1];
        end
    end

endmodule

// File: doc/rfft_ctrl.md
# rfft_ctrl

Sequencer for the 256-point radix-2 RFFT datapath: four 64-entry BRAM banks and one 4-in/4-out butterfly PE. On `start` it steps through all butterfly stages. For each stage it generates the bank read addresses, the delayed write addresses and write enable, the input/output bank-swap selects, the twiddle-ROM address and the PE bypass control. It then signals completion with a one-cycle `done` pulse. It replaces the ad-hoc counter logic inside the top-level FFT module.

## Interface
- `ADDR_W`, 6: bank address width; 2^ADDR_W = 64 entries per bank.
- `STAGES`, 7: number of stages; the last stage runs with the PE bypassed.
- `PE_LAT`, 2: PE pipeline latency in cycles. Total read-to-write latency is L = PE_LAT+1, which includes one BRAM read cycle.
- `Clk` input 1: sole clock, rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `start` input 1: request one full transform; sampled only in IDLE.
- `busy` output 1: high while a transform is in progress.
- `done` output 1: one-cycle completion pulse.
- `stage` output 3: current stage index, 0..STAGES-1.
- `rd_addr0` output ADDR_W: read address for banks 0/1.
- `rd_addr1` output ADDR_W: read address for banks 2/3.
- `wr_addr0` output ADDR_W: write address for banks 0/1.
- `wr_addr1` output ADDR_W: write address for banks 2/3.
- `we` output 1: write enable for all four banks.
- `in_swap` output 1: 1 = PE inputs take the pairs {bank2,bank0,bank3,bank1}; 0 = straight mapping.
- `out_swap` output 1: 1 = PE outputs 0/1 go to banks 2/3 and outputs 2/3 go to banks 0/1.
- `tf_addr` output ADDR_W: twiddle-ROM address.
- `bypass_n` output 1: 0 = PE passes data through without the butterfly.

## Operation
- FSM states:
  - IDLE: go to READ when `start`=1.
  - READ: go to FLUSH when cnt = 2^ADDR_W-1.
  - FLUSH: after L cycles, go to READ with stage+1; if stage = STAGES-1, go to DONE instead.
  - DONE: always go to IDLE after one cycle.
- Counters: `cnt` is the ADDR_W-bit read counter (0..63 in READ, cleared on entry to READ). `fc` is the flush counter (0..L-1).
- Read addressing during READ:
  - `rd_addr0` = cnt.
  - `rd_addr1` = cnt with its top `stage` bits inverted. Stage 0 inverts nothing; stage 6 inverts all bits.
- Input swap: `in_swap` = 0 in stage 0, and cnt[ADDR_W-stage] for stages 1..ADDR_W.
- Twiddle address: `tf_addr` = (cnt << stage) truncated to ADDR_W bits.
- Bypass: `bypass_n` = 0 only when stage = STAGES-1.
- Write-back pipeline: an L-deep shift register carries {valid, rd_addr0, rd_addr1, swap bit}. At the tail, `we` = valid and `wr_addr0/1` = the delayed addresses. `out_swap` = delayed cnt[ADDR_W-1-stage], or 0 in the last stage.
- The pipeline drains fully in FLUSH, so no write of stage s overlaps any read of stage s+1. This guarantees read-after-write across stages.
- `start` while busy, or in DONE, is ignored; no queuing.
- In IDLE and DONE, all address, select and `we` outputs are 0.

## Timing
- Reset values: `busy`=0, `done`=0, `stage`=0, `we`=0, all addresses=0, `in_swap`=0, `out_swap`=0, `tf_addr`=0, `bypass_n`=1. FSM = IDLE; pipeline valid bits are cleared.
- All outputs are registered.
- Cycle numbering: `start`=1 sampled at edge E0. Cycle 0 follows E0 and has `busy`=1 and `rd_addr0`=0 (stage 0, cnt 0).
- A read issued in cycle t is written in cycle t+L (`we`=1 during that cycle; the BRAM captures it at the end edge).
- Each stage lasts 64+L cycles: 64 READ cycles plus L FLUSH cycles. The last write of a stage lands in the last FLUSH cycle.
- `done`=1 and `busy`=0 in cycle STAGES·(64+L), which is 469 with the defaults. IDLE follows one cycle later; a new `start` is accepted from that edge.
- `Reset` asserted mid-transform: all outputs return to reset values immediately (asynchronously). Any in-flight write is dropped. No `done` pulse is produced.
- Counter wrap: cnt wraps 63→0 only on a FLUSH→READ transition; `stage` never exceeds STAGES-1.

## Configuration
- `RFFT_CTRL_ABORT_EN`:
  - Defined: adds input port `abort` (1 bit). `abort`=1 in READ or FLUSH forces `we`=0 on the next cycle, clears the pipeline, and jumps to IDLE with `busy`=0. No `done` pulse is produced. `abort` in IDLE or DONE is ignored.
  - Undefined: no `abort` port; a transform can only be terminated by `Reset`.

## Test plan
- Reset released, `start` pulsed once → `busy` rises at cycle 0, `done` pulses exactly at cycle 469, `busy`=0 from cycle 469.
- Stage 1 → at cnt=5: `rd_addr1`=37, `in_swap`=0, `tf_addr`=10; at cnt=40: `rd_addr1`=8, `in_swap`=1, `tf_addr`=16.
- Write pipeline → the read of cnt=n at stage-start+n produces `we`=1 with `wr_addr0`=n at stage-start+n+3; `we`=0 throughout READ cycles 0..2 of each stage.
- Last stage (6) → `bypass_n`=0, `rd_addr1` = ~cnt (cnt=0 → 63), `out_swap`=0 for all writes.
- `start` held high for 600 cycles → exactly one `done` at cycle 469; a second transform begins at cycle 471.
- `Reset` asserted at cycle 200 → `we`/`busy`/`stage` = 0 immediately, no `done`. With `RFFT_CTRL_ABORT_EN`: `abort` at cycle 100 → `busy`=0 and `we`=0 by cycle 101, no `done`.
